// File: rtl/symbol_streamer.sv
// -----------------------------------------------------------------------------
// symbol_streamer
//
// Buffers packed words of 2-bit symbols in a 2-entry FIFO and, on request,
// streams a programmed number of symbols (LSB pair of each word first). The
// stream is framed by BC_mode, followed by FLUSH idle cycles and a one-cycle
// done pulse.
//
// Every output except in_ready is registered. Each output register is loaded
// from the state the FSM holds at the edge, so the outputs show what the FSM
// did one cycle earlier.
//
// Parameters
//   DATA_W : packed input word width (even, >= 4)
//   LEN_W  : width of the sequence-length counter
//   FLUSH  : idle cycles sent after the last symbol of a run
//
// Ports
//   CLK        in   clock
//   RST        in   asynchronous, active-low reset
//   in_data    in   packed symbols, first symbol in bits [1:0]
//   in_valid   in   in_data is valid
//   in_ready   out  FIFO has a free entry (depends on the FIFO count only)
//   start      in   run request (acted on in IDLE only)
//   seq_len    in   number of symbols to send in the run
//   symbol     out  current symbol
//   sym_valid  out  symbol is meaningful this cycle
//   BC_mode    out  stream framing, high while symbols are being sent
//   busy       out  run in progress
//   done       out  one-cycle end-of-run pulse
// -----------------------------------------------------------------------------
module symbol_streamer #(
  parameter int DATA_W = 32,
  parameter int LEN_W  = 16,
  parameter int FLUSH  = 16
) (
  input  logic              CLK,
  input  logic              RST,
  input  logic [DATA_W-1:0] in_data,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic              start,
  input  logic [LEN_W-1:0]  seq_len,
  output logic [1:0]        symbol,
  output logic              sym_valid,
  output logic              BC_mode,
  output logic              busy,
  output logic              done
);

  localparam int SYMS  = DATA_W / 2;
  localparam int IDX_W = (SYMS > 1) ? $clog2(SYMS) : 1;
  localparam int FL_W  = (FLUSH > 1) ? $clog2(FLUSH) : 1;

  localparam logic [IDX_W-1:0] LAST_IDX   = IDX_W'(SYMS - 1);
  localparam logic [FL_W-1:0]  LAST_FLUSH = FL_W'((FLUSH > 0) ? FLUSH - 1 : 0);

  typedef enum logic [1:0] {
    S_IDLE,
    S_STREAM,
    S_FLUSH,
    S_DONE
  } state_e;

  // ---------------------------------------------------------------------------
  // Registers and next-state signals
  // ---------------------------------------------------------------------------
  state_e             state_q,     state_d;
  logic [LEN_W-1:0]   rem_q,       rem_d;
  logic [IDX_W-1:0]   idx_q,       idx_d;
  logic [FL_W-1:0]    fcnt_q,      fcnt_d;
  logic [1:0]         symbol_q,    symbol_d;
  logic               sym_valid_q, sym_valid_d;
  logic               bc_mode_q,   bc_mode_d;
  logic               busy_q,      busy_d;
  logic               done_q,      done_d;

  // FIFO bookkeeping
  logic [1:0]         count_q,     count_d;
  logic               wr_ptr_q,    wr_ptr_d;
  logic               rd_ptr_q,    rd_ptr_d;
  logic [DATA_W-1:0]  mem_q [0:1];

  logic               push;
  logic               pop;
  logic [DATA_W-1:0]  head_word;
  logic [1:0]         head_sym;

  // ---------------------------------------------------------------------------
  // FIFO access
  // ---------------------------------------------------------------------------
  // Readiness looks at the stored count only, so a pop in the same cycle never
  // opens the door for a push into a full FIFO.
  assign in_ready  = (count_q < 2'd2);
  assign push      = in_valid && in_ready;
  assign head_word = mem_q[rd_ptr_q];
  assign head_sym  = head_word[{idx_q, 1'b0} +: 2];

  always_comb begin
    count_d  = count_q;
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    if (push) begin
      wr_ptr_d = ~wr_ptr_q;
    end
    if (pop) begin
      rd_ptr_d = ~rd_ptr_q;
    end
    unique case ({push, pop})
      2'b10:   count_d = count_q + 2'd1;
      2'b01:   count_d = count_q - 2'd1;
      default: count_d = count_q;
    endcase
  end

  // NOTE: the word storage has no reset; the count and pointers define which
  // entries are live, so stale data after reset is never observed.
  always_ff @(posedge CLK) begin
    if (push) begin
      mem_q[wr_ptr_q] <= in_data;
    end
  end

  // ---------------------------------------------------------------------------
  // FSM next-state and registered-output logic
  // ---------------------------------------------------------------------------
  // NOTE: every signal written here gets a default first, so no path through
  // the case statement can leave a value unassigned and infer a latch.
  always_comb begin
    state_d     = state_q;
    rem_d       = rem_q;
    idx_d       = idx_q;
    fcnt_d      = fcnt_q;
    symbol_d    = 2'b00;
    sym_valid_d = 1'b0;
    bc_mode_d   = 1'b0;
    busy_d      = (state_q != S_IDLE);
    done_d      = 1'b0;
    pop         = 1'b0;

    unique case (state_q)
      S_IDLE: begin
        if (start) begin
          if (seq_len != '0) begin
            rem_d   = seq_len;
            state_d = S_STREAM;
          end else begin
            state_d = S_DONE;
          end
        end
      end

      S_STREAM: begin
        bc_mode_d = 1'b1;
        if (count_q != 2'd0) begin
          symbol_d    = head_sym;
          sym_valid_d = 1'b1;
          rem_d       = rem_q - LEN_W'(1);
          // A word leaves the FIFO after its last symbol, or early when the
          // run ends inside it; its unsent symbols are dropped.
          if (idx_q == LAST_IDX || rem_q == LEN_W'(1)) begin
            pop   = 1'b1;
            idx_d = '0;
          end else begin
            idx_d = idx_q + IDX_W'(1);
          end
          if (rem_q == LEN_W'(1)) begin
            fcnt_d  = '0;
            state_d = (FLUSH == 0) ? S_DONE : S_FLUSH;
          end
        end else begin
          // Underflow: keep the last symbol on the bus, framing stays up.
          symbol_d = symbol_q;
        end
      end

      S_FLUSH: begin
        if (fcnt_q == LAST_FLUSH) begin
          state_d = S_DONE;
        end else begin
          fcnt_d = fcnt_q + FL_W'(1);
        end
      end

      S_DONE: begin
        done_d  = 1'b1;
        state_d = S_IDLE;
      end

      default: begin
        state_d = S_IDLE;
      end
    endcase
  end

  // ---------------------------------------------------------------------------
  // State register
  // ---------------------------------------------------------------------------
  // NOTE: sequential state uses non-blocking assignments so every register
  // samples the pre-edge values, independent of statement order.
  always_ff @(posedge CLK or negedge RST) begin
    if (!RST) begin
      state_q     <= S_IDLE;
      rem_q       <= '0;
      idx_q       <= '0;
      fcnt_q      <= '0;
      symbol_q    <= 2'b00;
      sym_valid_q <= 1'b0;
      bc_mode_q   <= 1'b0;
      busy_q      <= 1'b0;
      done_q      <= 1'b0;
      count_q     <= 2'd0;
      wr_ptr_q    <= 1'b0;
      rd_ptr_q    <= 1'b0;
    end else begin
      state_q     <= state_d;
      rem_q       <= rem_d;
      idx_q       <= idx_d;
      fcnt_q      <= fcnt_d;
      symbol_q    <= symbol_d;
      sym_valid_q <= sym_valid_d;
      bc_mode_q   <= bc_mode_d;
      busy_q      <= busy_d;
      done_q      <= done_d;
      count_q     <= count_d;
      wr_ptr_q    <= wr_ptr_d;
      rd_ptr_q    <= rd_ptr_d;
    end
  end

  assign symbol    = symbol_q;
  assign sym_valid = sym_valid_q;
  assign BC_mode   = bc_mode_q;
  assign busy      = busy_q;
  assign done      = done_q;

endmodule

// File: tb/tb_symbol_streamer.sv
// -----------------------------------------------------------------------------
// tb_symbol_streamer
//
// Self-checking bench for symbol_streamer with default parameters
// (DATA_W=32, LEN_W=16, FLUSH=16). Table-driven single-run vectors, directed
// multi-cycle corner cases (underflow, two-word partial pop, mid-run reset)
// and randomized runs compared against a queue-based reference model.
// -----------------------------------------------------------------------------
module tb_symbol_streamer;

  localparam int DATA_W = 32;
  localparam int LEN_W  = 16;
  localparam int FLUSH  = 16;

  logic              CLK;
  logic              RST;
  logic [DATA_W-1:0] in_data;
  logic              in_valid;
  logic              in_ready;
  logic              start;
  logic [LEN_W-1:0]  seq_len;
  logic [1:0]        symbol;
  logic              sym_valid;
  logic              BC_mode;
  logic              busy;
  logic              done;

  int checks = 0;
  int errors = 0;

  symbol_streamer #(
    .DATA_W (DATA_W),
    .LEN_W  (LEN_W),
    .FLUSH  (FLUSH)
  ) dut (
    .CLK       (CLK),
    .RST       (RST),
    .in_data   (in_data),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .start     (start),
    .seq_len   (seq_len),
    .symbol    (symbol),
    .sym_valid (sym_valid),
    .BC_mode   (BC_mode),
    .busy      (busy),
    .done      (done)
  );

  initial begin
    CLK = 1'b0;
    forever #5 CLK = ~CLK;
  end

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation did not reach its summary");
    $fatal(1, "watchdog expired");
  end

  // ---------------------------------------------------------------------------
  // Helpers
  // ---------------------------------------------------------------------------
  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
    end
  endtask

  // Advance one edge; outputs are sampled 1 ns after it.
  task automatic tick();
    @(posedge CLK);
    #1;
  endtask

  task automatic push_word(input string name, input logic [DATA_W-1:0] w);
    check({name, "_push_ready"}, in_ready, 1'b1);
    in_valid = 1'b1;
    in_data  = w;
    tick();
    in_valid = 1'b0;
  endtask

  // Watch a run until done, cycle numbers counted from the start edge.
  task automatic collect(input int cyc0, output logic [63:0] syms, output int vc,
                         output int bc, output int lat, output int first,
                         output int bad, output int busyc);
    int cyc;
    syms = '0; vc = 0; bc = 0; lat = -1; first = -1; bad = 0; busyc = 0;
    cyc = cyc0;
    while (lat < 0 && cyc < cyc0 + 400) begin
      tick();
      cyc++;
      if (sym_valid) begin
        if (vc < 32) syms[2*vc +: 2] = symbol;
        if (first < 0) first = cyc;
        vc++;
      end
      if (BC_mode) bc++;
      else if (symbol != 2'b00 || sym_valid) bad++;
      if (busy) busyc++;
      if (done) lat = cyc;
    end
  endtask

  task automatic run_vec(input string name, input bit preload, input logic [DATA_W-1:0] word,
                         input int len, input logic [63:0] exp_syms, input int exp_lat);
    logic [63:0] syms;
    int vc, bc, lat, first, bad, busyc;
    if (preload) push_word(name, word);
    start   = 1'b1;
    seq_len = LEN_W'(len);
    tick();
    start   = 1'b0;
    collect(0, syms, vc, bc, lat, first, bad, busyc);
    check({name, "_syms"},       syms,  exp_syms);
    check({name, "_count"},      vc,    len);
    check({name, "_bc_cycles"},  bc,    len);
    check({name, "_done_lat"},   lat,   exp_lat);
    check({name, "_flush_zero"}, bad,   0);
    check({name, "_busy"},       busyc, exp_lat);
    tick();
    check({name, "_end_done_busy"}, {done, busy}, 2'b00);
    check({name, "_end_ready"},     in_ready,     1'b1);
  endtask

  // ---------------------------------------------------------------------------
  // Reference model for randomized runs: a queue of accepted words, consumed
  // LSB pair first; the run's final symbol retires its word.
  // ---------------------------------------------------------------------------
  typedef enum {M_IDLE, M_RUN, M_TAIL} mphase_e;
  mphase_e           m_phase;
  logic [DATA_W-1:0] mq[$];
  int                m_rem, m_idx, m_tail, vprob;

  task automatic step(input bit do_start, input int len);
    logic [DATA_W-1:0] head;
    bit                exp_rdy, exp_v, exp_busy, exp_done, was_run;
    logic [1:0]        exp_sym;
    exp_rdy = (mq.size() < 2);
    check("rnd_in_ready", in_ready, exp_rdy);
    in_valid = ($urandom_range(0, 99) < vprob);
    in_data  = $urandom;
    start    = do_start;
    seq_len  = LEN_W'(len);
    exp_v    = 1'b0;
    exp_sym  = 2'b00;
    if (m_phase == M_RUN && mq.size() > 0) begin
      head    = mq[0];
      exp_v   = 1'b1;
      exp_sym = head[2*m_idx +: 2];
    end
    exp_busy = (m_phase != M_IDLE);
    exp_done = (m_phase == M_TAIL && m_tail == FLUSH);
    was_run  = (m_phase == M_RUN);
    tick();
    start = 1'b0;
    if (in_valid && exp_rdy) mq.push_back(in_data);
    in_valid = 1'b0;
    check("rnd_busy",      busy,      exp_busy);
    check("rnd_done",      done,      exp_done);
    check("rnd_bc_mode",   BC_mode,   was_run);
    check("rnd_sym_valid", sym_valid, exp_v);
    if (exp_v) check("rnd_symbol", symbol, exp_sym);
    else if (!was_run) check("rnd_symbol_zero", symbol, 2'b00);
    case (m_phase)
      M_IDLE: begin
        if (do_start) begin
          if (len == 0) begin
            m_phase = M_TAIL;
            m_tail  = FLUSH;
          end else begin
            m_phase = M_RUN;
            m_rem   = len;
            m_idx   = 0;
          end
        end
      end
      M_RUN: begin
        if (exp_v) begin
          m_rem--;
          m_idx++;
          if (m_idx == DATA_W/2 || m_rem == 0) begin
            void'(mq.pop_front());
            m_idx = 0;
          end
          if (m_rem == 0) begin
            m_phase = M_TAIL;
            m_tail  = 0;
          end
        end
      end
      default: begin
        m_tail++;
        if (m_tail == FLUSH + 1) m_phase = M_IDLE;
      end
    endcase
  endtask

  // ---------------------------------------------------------------------------
  // Vector table
  // ---------------------------------------------------------------------------
  typedef struct {
    string             name;
    bit                preload;
    logic [DATA_W-1:0] word;
    int                len;
    logic [63:0]       exp_syms;
    int                exp_lat;
  } vec_t;

  vec_t vecs[7];

  // ---------------------------------------------------------------------------
  // Test sequence
  // ---------------------------------------------------------------------------
  initial begin
    logic [63:0] syms;
    int vc, bc, lat, first, bad, busyc, uf_bad, rst_done, gap, len, steps;

    RST = 1'b1; start = 1'b0; in_valid = 1'b0; in_data = '0; seq_len = '0;
    #1 RST = 1'b0;
    #1;
    check("reset_symbol",    symbol,    2'b00);
    check("reset_sym_valid", sym_valid, 1'b0);
    check("reset_bc_mode",   BC_mode,   1'b0);
    check("reset_busy",      busy,      1'b0);
    check("reset_done",      done,      1'b0);
    check("reset_in_ready",  in_ready,  1'b1);
    repeat (2) tick();
    RST = 1'b1;
    tick();

    // name, preload, word, seq_len, expected packed symbols, done latency
    vecs[0] = '{"e4_full",   1'b1, 32'hE4E4_E4E4, 16, 64'hE4E4_E4E4, 33};
    vecs[1] = '{"e4_four",   1'b1, 32'hE4E4_E4E4,  4, 64'h0000_00E4, 21};
    vecs[2] = '{"one_sym",   1'b1, 32'h1B1B_1B1B,  1, 64'h0000_0003, 18};
    vecs[3] = '{"all_three", 1'b1, 32'hFFFF_FFFF, 16, 64'hFFFF_FFFF, 33};
    vecs[4] = '{"half_word", 1'b1, 32'h1234_5678,  8, 64'h0000_5678, 25};
    vecs[5] = '{"zero_len",  1'b0, 32'h0000_0000,  0, 64'h0000_0000,  1};
    vecs[6] = '{"fifteen",   1'b1, 32'h9C9C_9C9C, 15, 64'h1C9C_9C9C, 32};
    for (int i = 0; i < 7; i++) begin
      run_vec(vecs[i].name, vecs[i].preload, vecs[i].word, vecs[i].len,
              vecs[i].exp_syms, vecs[i].exp_lat);
    end

    // Underflow: empty FIFO at start, word arrives later; a second start
    // during the run is ignored.
    start = 1'b1; seq_len = 16; tick(); start = 1'b0;
    uf_bad = 0;
    for (int c = 1; c <= 5; c++) begin
      if (c == 2) begin start = 1'b1; seq_len = 2; end
      tick();
      start = 1'b0;
      if (sym_valid || !BC_mode || !busy) uf_bad++;
    end
    check("uf_wait_cycles", uf_bad, 0);
    in_valid = 1'b1; in_data = 32'h1B1B_1B1B; tick(); in_valid = 1'b0;
    check("uf_push_edge_valid", sym_valid, 1'b0);
    check("uf_push_edge_bc",    BC_mode,   1'b1);
    collect(6, syms, vc, bc, lat, first, bad, busyc);
    check("uf_first_symbol_cycle", first, 7);
    check("uf_syms",       syms,  64'h1B1B_1B1B);
    check("uf_count",      vc,    16);
    check("uf_bc_cycles",  bc,    16);
    check("uf_done_lat",   lat,   39);
    check("uf_flush_zero", bad,   0);
    check("uf_busy",       busyc, 33);
    tick();

    // Two words, run ends 4 symbols into the second; its rest is dropped.
    push_word("two_w1", 32'hE4E4_E4E4);
    push_word("two_w2", 32'h0000_001B);
    check("two_full_not_ready", in_ready, 1'b0);
    run_vec("two_word", 1'b0, '0, 20, 64'h0000_001B_E4E4_E4E4, 37);
    // FIFO empty afterwards: two more words fit, and both stream back.
    push_word("after_w1", 32'hAAAA_AAAA);
    check("after_one_word_ready", in_ready, 1'b1);
    push_word("after_w2", 32'h5555_5555);
    check("after_two_words_full", in_ready, 1'b0);
    run_vec("two_full_words", 1'b0, '0, 32, 64'h5555_5555_AAAA_AAAA, 49);

    // Reset in the middle of a run.
    push_word("abort_w1", 32'hE4E4_E4E4);
    push_word("abort_w2", 32'hFFFF_FFFF);
    start = 1'b1; seq_len = 32; tick(); start = 1'b0;
    repeat (6) tick();
    check("pre_reset_symbol", {sym_valid, BC_mode, busy, symbol}, 5'b111_01);
    #2 RST = 1'b0;
    #1;
    check("mid_reset_symbol",    symbol,    2'b00);
    check("mid_reset_sym_valid", sym_valid, 1'b0);
    check("mid_reset_bc_mode",   BC_mode,   1'b0);
    check("mid_reset_busy",      busy,      1'b0);
    check("mid_reset_in_ready",  in_ready,  1'b1);
    rst_done = 0;
    repeat (3) begin
      tick();
      if (done) rst_done++;
    end
    check("mid_reset_no_done", rst_done, 0);
    RST = 1'b1;
    tick();
    run_vec("after_reset", 1'b1, 32'hE4E4_E4E4, 16, 64'hE4E4_E4E4, 33);

    // Randomized runs against the model (FIFO is empty here).
    mq.delete();
    m_phase = M_IDLE; m_rem = 0; m_idx = 0; m_tail = 0;
    for (int r = 0; r < 12; r++) begin
      vprob = (r % 4 == 0) ? 100 : $urandom_range(10, 90);
      gap = $urandom_range(0, 3);
      repeat (gap) step(1'b0, 0);
      len = (r == 5) ? 0 : $urandom_range(1, 40);
      step(1'b1, len);
      steps = 0;
      while (m_phase != M_IDLE && steps < 400) begin
        step($urandom_range(0, 7) == 0, $urandom_range(0, 40));
        steps++;
      end
      check("rnd_run_finished", (m_phase == M_IDLE), 1'b1);
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
